// File: rtl/multi_clock_divider.sv
// multi_clock_divider: CHANNELS independent clock dividers driven from one board clock.
// Each channel counts to a runtime-loadable half-period. It produces a registered divided
// level (square or pulse) and a one-cycle tick at every counter wrap. A new half-period
// and mode are held in a shadow register until the channel's next wrap, or until the
// next edge on which the channel is disabled.
module multi_clock_divider #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 20,
  parameter int SEL_W        = 2,
  parameter int DEFAULT_HALF = 500000
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic [CHANNELS-1:0] i_EN,
  input  logic                i_LD,
  input  logic [SEL_W-1:0]    i_LD_SEL,
  input  logic [CNT_W-1:0]    i_LD_VAL,
  input  logic                i_LD_MODE,
  output logic [CHANNELS-1:0] o_CLK,
  output logic [CHANNELS-1:0] o_TICK,
  output logic [CHANNELS-1:0] o_PEND,
  output logic                o_ERR
);

  localparam logic [CNT_W-1:0] DEF_HP = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Per-channel state
  logic [CNT_W-1:0]    r_cnt   [CHANNELS];
  logic [CNT_W-1:0]    r_hp    [CHANNELS];
  logic [CNT_W-1:0]    r_sh_hp [CHANNELS];
  logic [CHANNELS-1:0] r_md;
  logic [CHANNELS-1:0] r_sh_md;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_clk;
  logic [CHANNELS-1:0] r_tick;
  logic                r_err;

  // Decoded load and per-channel next-state terms
  logic                w_sel_ok;
  logic                w_ld_ok;
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_wrap;
  logic [CHANNELS-1:0] w_apply;
  logic [CHANNELS-1:0] w_new_md;
  logic [CHANNELS-1:0] w_clk_nxt;
  logic [CNT_W-1:0]    w_new_hp [CHANNELS];

  assign w_sel_ok = (32'(i_LD_SEL) < 32'(CHANNELS));
  assign w_ld_ok  = i_LD && w_sel_ok && (i_LD_VAL != '0);

  // Per-channel wrap detection, shadow bypass and apply decision
  always_comb begin
    w_hit     = '0;
    w_wrap    = '0;
    w_apply   = '0;
    w_new_md  = '0;
    w_clk_nxt = '0;
    w_new_hp  = '{default: '0};
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i]    = w_ld_ok && (32'(i_LD_SEL) == 32'(i));
      w_wrap[i]   = i_EN[i] && (r_cnt[i] == (r_hp[i] - ONE));
      // A load arriving on the wrap edge is applied on that same edge.
      w_new_hp[i] = w_hit[i] ? i_LD_VAL  : r_sh_hp[i];
      w_new_md[i] = w_hit[i] ? i_LD_MODE : r_sh_md[i];
      // Running channels apply on a wrap; idle channels apply a load latched earlier.
      if (i_EN[i])
        w_apply[i] = w_wrap[i] && (r_pend[i] || w_hit[i]);
      else
        w_apply[i] = r_pend[i] && !w_hit[i];
      // A mode change restarts the level at 0; pulse mode follows the tick.
      if (w_apply[i] && (w_new_md[i] != r_md[i]))
        w_clk_nxt[i] = 1'b0;
      else if (r_md[i])
        w_clk_nxt[i] = w_wrap[i];
      else
        w_clk_nxt[i] = r_clk[i] ^ w_wrap[i];
    end
  end

  // Counters, active configuration, pending flags and registered outputs
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
        r_hp[i]  <= DEF_HP;
      end
      r_md   <= '0;
      r_pend <= '0;
      r_clk  <= '0;
      r_tick <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= i_LD && !w_ld_ok;
      r_tick <= w_wrap;
      r_clk  <= w_clk_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_apply[i]) begin
          r_cnt[i]  <= '0;
          r_hp[i]   <= w_new_hp[i];
          r_md[i]   <= w_new_md[i];
          r_pend[i] <= 1'b0;
        end else begin
          if (i_EN[i])
            r_cnt[i] <= w_wrap[i] ? '0 : (r_cnt[i] + ONE);
          if (w_hit[i])
            r_pend[i] <= 1'b1;
        end
      end
    end
  end

  // Shadow configuration; last accepted load wins, only meaningful while pend is set
  always_ff @(posedge i_CLK) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_hit[i]) begin
        r_sh_hp[i] <= i_LD_VAL;
        r_sh_md[i] <= i_LD_MODE;
      end
    end
  end

  assign o_CLK  = r_clk;
  assign o_TICK = r_tick;
  assign o_PEND = r_pend;
  assign o_ERR  = r_err;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: directed stimulus pushes hand-computed
// expected outputs tagged with the clock edge after which they must hold; a monitor
// compares them one time unit after each rising edge.
module tb_multi_clock_divider;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       en;
  logic [2:0]       en3;
  logic             ld, ld3;
  logic [1:0]       sel;
  logic [CNT_W-1:0] val;
  logic             mode;

  logic [3:0] o_clk, o_tick, o_pend;
  logic       o_err;
  logic [2:0] clk3, tick3, pend3;
  logic       err3;

  multi_clock_divider #(.CHANNELS(4), .CNT_W(CNT_W), .SEL_W(2), .DEFAULT_HALF(5)) u_dut (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_LD(ld), .i_LD_SEL(sel),
    .i_LD_VAL(val), .i_LD_MODE(mode),
    .o_CLK(o_clk), .o_TICK(o_tick), .o_PEND(o_pend), .o_ERR(o_err)
  );

  multi_clock_divider #(.CHANNELS(3), .CNT_W(CNT_W), .SEL_W(2), .DEFAULT_HALF(5)) u_dut3 (
    .i_CLK(clk), .i_RST(rst), .i_EN(en3), .i_LD(ld3), .i_LD_SEL(sel),
    .i_LD_VAL(val), .i_LD_MODE(mode),
    .o_CLK(clk3), .o_TICK(tick3), .o_PEND(pend3), .o_ERR(err3)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  localparam int S_CLK = 0, S_TICK = 1, S_PEND = 2, S_ERR = 3;
  localparam int S_ERR3 = 4, S_PEND3 = 5, S_TICK3 = 6;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic string sname(input int s);
    case (s)
      S_CLK:   return "CLK";
      S_TICK:  return "TICK";
      S_PEND:  return "PEND";
      S_ERR:   return "ERR";
      S_ERR3:  return "ERR_3CH";
      S_PEND3: return "PEND_3CH";
      default: return "TICK_3CH";
    endcase
  endfunction

  function automatic logic [3:0] actual(input int s);
    case (s)
      S_CLK:   return o_clk;
      S_TICK:  return o_tick;
      S_PEND:  return o_pend;
      S_ERR:   return {3'b000, o_err};
      S_ERR3:  return {3'b000, err3};
      S_PEND3: return {1'b0, pend3};
      default: return {1'b0, tick3};
    endcase
  endfunction

  // expected value of signal s in the cycle following edge c
  task automatic chk(input int c, input int s, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic at(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == edge_cnt) begin
          logic [3:0] a;
          a = actual(exp_q[i].sig);
          n_checks++;
          if (a !== exp_q[i].val) begin
            n_fail++;
            $display("FAIL %s after edge %0d: got %b expected %b",
                     sname(exp_q[i].sig), edge_cnt, a, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 4'h0; en3 = 3'b111; ld = 1'b0; ld3 = 1'b0;
    sel = '0; val = '0; mode = 1'b0;

    // Reset state, then release with all channels enabled (last reset edge 4)
    at(3);
    en = 4'hF;
    chk(4, S_CLK, 4'h0); chk(4, S_TICK, 4'h0); chk(4, S_PEND, 4'h0);
    chk(4, S_ERR, 4'h0); chk(4, S_PEND3, 4'h0);
    at(4);
    rst = 1'b0;
    chk(8, S_TICK, 4'h0);  chk(9, S_TICK, 4'hF);  chk(9, S_CLK, 4'hF);
    chk(9, S_PEND, 4'h0);  chk(9, S_ERR, 4'h0);   chk(10, S_TICK, 4'h0);
    chk(13, S_CLK, 4'hF);  chk(14, S_TICK, 4'hF); chk(14, S_CLK, 4'h0);
    chk(19, S_CLK, 4'hF);

    // ch2 <- H=3 square, mid-period; applied at ch2's wrap on edge 24
    at(20);
    ld = 1'b1; sel = 2'd2; val = 8'd3; mode = 1'b0;
    chk(21, S_PEND, 4'b0100); chk(23, S_PEND, 4'b0100); chk(24, S_PEND, 4'b0000);
    chk(24, S_TICK, 4'hF);    chk(24, S_CLK, 4'h0);
    chk(27, S_TICK, 4'b0100); chk(27, S_CLK, 4'b0100);
    chk(29, S_TICK, 4'b1011); chk(29, S_CLK, 4'b1111);
    chk(30, S_TICK, 4'b0100); chk(30, S_CLK, 4'b1011);
    at(21);
    ld = 1'b0;

    // ch1 <- H=2 pulse while ch1 disabled; applied on the following edge
    at(34);
    en = 4'b1101;
    at(35);
    ld = 1'b1; sel = 2'd1; val = 8'd2; mode = 1'b1;
    chk(36, S_PEND, 4'b0010); chk(37, S_PEND, 4'b0000); chk(37, S_CLK, 4'b0000);
    at(36);
    ld = 1'b0;
    at(38);
    en = 4'hF;
    chk(40, S_TICK, 4'b0010); chk(40, S_CLK, 4'b1111);
    chk(41, S_TICK, 4'b0000); chk(41, S_CLK, 4'b1101);
    chk(42, S_TICK, 4'b0110); chk(42, S_CLK, 4'b1011);

    // Rejected load: LD_VAL=0
    at(42);
    ld = 1'b1; sel = 2'd0; val = 8'd0; mode = 1'b0;
    chk(43, S_ERR, 4'h1); chk(43, S_PEND, 4'h0); chk(43, S_ERR3, 4'h0);
    chk(44, S_ERR, 4'h0); chk(44, S_TICK, 4'b1011);
    at(43);
    ld = 1'b0;

    // Rejected load: LD_SEL=3 on the three-channel instance
    at(44);
    ld3 = 1'b1; sel = 2'd3; val = 8'd7;
    chk(45, S_ERR3, 4'h1); chk(45, S_PEND3, 4'h0); chk(45, S_ERR, 4'h0);
    chk(46, S_ERR3, 4'h0); chk(49, S_TICK3, 4'b0111);
    at(45);
    ld3 = 1'b0;

    // ch0 <- H=4 on the exact edge ch0 wraps (edge 54)
    at(53);
    ld = 1'b1; sel = 2'd0; val = 8'd4; mode = 1'b0;
    chk(54, S_TICK, 4'hF);    chk(54, S_CLK, 4'b0010); chk(54, S_PEND, 4'h0);
    chk(55, S_TICK, 4'b0000); chk(56, S_TICK, 4'b0010);
    chk(57, S_TICK, 4'b0100); chk(58, S_TICK, 4'b0011); chk(58, S_CLK, 4'b0111);
    at(54);
    ld = 1'b0;

    // Long periods on idle channels, then pending loads on all, then reset
    at(59);
    en = 4'h0;
    ld = 1'b1; sel = 2'd0; val = 8'd100; mode = 1'b0;
    at(60); sel = 2'd1;
    chk(61, S_PEND, 4'b0010);
    at(61); sel = 2'd2;
    at(62); sel = 2'd3;
    at(63); ld = 1'b0;
    chk(64, S_PEND, 4'b0000);
    at(64); en = 4'hF;
    at(65); ld = 1'b1; sel = 2'd0; val = 8'd7; mode = 1'b1;
    at(66); sel = 2'd1;
    at(67); sel = 2'd2;
    at(68); sel = 2'd3;
    chk(69, S_PEND, 4'hF);
    at(69);
    rst = 1'b1; sel = 2'd2; val = 8'd9;
    chk(70, S_CLK, 4'h0);  chk(70, S_TICK, 4'h0); chk(70, S_PEND, 4'h0);
    chk(70, S_ERR, 4'h0);  chk(70, S_PEND3, 4'h0); chk(70, S_TICK3, 4'h0);
    at(70);
    rst = 1'b0; ld = 1'b0;
    chk(71, S_PEND, 4'h0); chk(74, S_TICK, 4'h0);
    chk(75, S_TICK, 4'hF); chk(75, S_CLK, 4'hF);
    chk(80, S_TICK, 4'hF); chk(80, S_CLK, 4'h0);

    at(82);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
